mem_port_responder: RTL and testbench
=====================================

# mem_port_responder

Memory-side responder for the single-port array interface that our generated kernels drive: `*_ce0`, `*_we0`, `*_address0`, `*_ad0` in, `*_q0` out. It holds the array storage, answers kernel reads after a fixed registered latency, and accepts kernel writes. A host-side port loads and inspects contents around a kernel run. One instance is placed per array argument in the kernel test harness and the SoC wrapper.

## Interface
- `ADDR_W`, default 32: kernel address width.
- `DATA_W`, default 32: data width.
- `DEPTH`, default 256: number of words, power of two.
- `RD_LAT`, default 2: cycles from a sampled read to valid `q0`. Legal range is 1..4.
- `ap_clk`, in, 1: clock.
- `ap_rst_n`, in, 1: reset, asynchronous, active-low.
- `ce0`, in, 1: kernel read enable.
- `we0`, in, 1: kernel write enable.
- `address0`, in, ADDR_W: kernel word address.
- `ad0`, in, DATA_W: kernel write data.
- `q0`, out, DATA_W: kernel read data.
- `host_en`, in, 1: host access request.
- `host_we`, in, 1: host write (1) or read (0).
- `host_addr`, in, log2(DEPTH): host word address.
- `host_wdata`, in, DATA_W: host write data.
- `host_ready`, out, 1: host request granted this cycle.
- `host_rdata`, out, DATA_W: host read data.
- `host_rvalid`, out, 1: one-cycle pulse marking `host_rdata` valid.
- `rd_count`, out, 32: count of accepted kernel reads.
- `wr_count`, out, 32: count of accepted kernel writes.
- `err_oor`, out, 1: sticky out-of-range flag.

## Operation
- **Kernel write**
  - Occurs on any cycle with `we0=1`, regardless of `ce0`. Kernels assert `we0` without `ce0`.
  - Writes `ad0` to `mem[address0]` at the clock edge.
  - A `we0` held for N cycles performs N writes and adds N to `wr_count`.
- **Kernel read**
  - Occurs on any cycle with `ce0=1` and `we0=0`.
  - `mem[address0]` enters the read pipeline; `rd_count` increments.
  - A `ce0` held for N cycles yields N reads.
- **Read and write in the same cycle** (`ce0=1`, `we0=1`)
  - Counts as a write only.
  - The pipeline still carries the pre-write value (read-first). `rd_count` does not increment.
- **`q0` hold:** `q0` keeps the last delivered read result until a newer one arrives. Kernels sample `q0` late.
- **Out of range** (`address0 >= DEPTH`)
  - Reads deliver 0; writes are dropped; counters do not increment.
- **Host arbitration**
  - The kernel has priority. `host_ready = host_en & ~ce0 & ~we0`.
  - The host holds its request until `host_ready=1`.
  - A granted host write updates memory at that edge.
  - A granted host read pulses `host_rvalid` the next cycle, with `host_rdata` held afterwards.
- **Counters:** both are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- **Reset values:** `q0=0`, `host_rdata=0`, `host_rvalid=0`, `rd_count=0`, `wr_count=0`, `err_oor=0`. `host_ready` is combinational.
- **Memory contents:** not reset; they persist across reset.
- **Read latency:** a read sampled at edge t shows on `q0` after edge t+RD_LAT. The pipeline is fully pipelined, one read per cycle.
- **Reset mid-operation:** in-flight reads are discarded. No `q0` update occurs from pre-reset reads, and no host pulse is delivered.
- **Write-to-read turnaround:** a write at edge t is visible to a read sampled at edge t+1.

## Configuration
- Macro `MEM_PORT_RESPONDER_OOR_CHECK_EN`.
- **Defined:**
  - Any kernel access with `address0 >= DEPTH` sets `err_oor` on the next edge. It stays set until reset.
  - The first offending address is captured in an internal register readable in simulation.
- **Undefined:** `err_oor` is tied to 0 and no capture logic is built. Out-of-range behaviour is otherwise identical.

## Structure
- Package `mem_port_pkg` holds:
  - default `ADDR_W`, `DATA_W`, `DEPTH`;
  - `RD_LAT` min/max constants;
  - a host-op typedef (`HOST_RD`, `HOST_WR`).
- Sub-module `mem_rd_pipe`: a RD_LAT-deep valid/data shift register with a hold-last output register. It is used for `q0`.

## Test plan
- **Host load, then kernel read** (RD_LAT=2): host writes `mem[5]=0x1234`, then `ce0=1`, `address0=5` for one cycle at edge t -> `q0=0x1234` after t+2 and held; `rd_count=1`.
- **Kernel write without `ce0`:** `we0=1`, `ce0=0`, `address0=3`, `ad0=0xA` for 3 cycles -> host read of 3 returns 0xA with a one-cycle `host_rvalid`; `wr_count=3`.
- **Read-first collision:** `mem[7]=1`; `ce0=we0=1`, `address0=7`, `ad0=2` -> `q0=1` two cycles later; the next read of 7 returns 2; `rd_count` is unchanged by the collision cycle.
- **Host stall:** `host_en=1` (read, addr 0) while `ce0=1` for 4 cycles -> `host_ready=0` for those 4 cycles, then granted, with `host_rvalid` one cycle later.
- **Out of range** (DEPTH=256): write to 300, then read 300 -> no memory change, `q0=0`.
  - Macro defined: `err_oor=1` and sticky.
  - Macro undefined: `err_oor` stays 0.
- **Reset with read in flight:** `mem[1]=0x55`, read 1 at edge t, `ap_rst_n` low at t+1 -> `q0=0` immediately and stays 0 after release; `mem[1]` still reads 0x55 afterwards.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared defaults and types for the kernel-array memory responder.
// The out-of-range checker is built only when MEM_PORT_RESPONDER_OOR_CHECK_EN is defined.
package mem_port_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 256;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        HOST_RD = 1'b0,
        HOST_WR = 1'b1
    } host_op_e;

    // Keeps the read pipeline buildable if a parent passes an out-of-range latency.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) begin
            return RD_LAT_MIN;
        end
        if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-deep valid/data shift register followed by a hold-last output register.
// The output only changes when a valid word leaves the last stage.
module mem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] q
);

    logic              last_valid;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] q_reg;

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic              valid_reg;
        logic [DATA_W-1:0] data_reg;
        logic              prev_valid;
        logic [DATA_W-1:0] prev_data;

        if (gi == 0) begin : g_src
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_src
            assign prev_valid = g_stage[gi-1].valid_reg;
            assign prev_data  = g_stage[gi-1].data_reg;
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= prev_valid;
                data_reg  <= prev_data;
            end
        end
    end

    assign last_valid = g_stage[RD_LAT-1].valid_reg;
    assign last_data  = g_stage[RD_LAT-1].data_reg;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            q_reg <= '0;
        end else if (last_valid) begin
            q_reg <= last_data;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder for a kernel single-port array (ce0/we0/address0/ad0/q0) plus a host load/inspect port.
// Optional sticky out-of-range flag: define MEM_PORT_RESPONDER_OOR_CHECK_EN.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int RD_LAT = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ce0,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        address0,
    input  logic [DATA_W-1:0]        ad0,
    output logic [DATA_W-1:0]        q0,
    input  logic                     host_en,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [DATA_W-1:0]        host_wdata,
    output logic                     host_ready,
    output logic [DATA_W-1:0]        host_rdata,
    output logic                     host_rvalid,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic                     err_oor
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PIPE_LAT = clamp_rd_lat(RD_LAT);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  k_idx;
    logic              k_in_range;
    logic              k_wr;
    logic              k_rd_count;
    logic [DATA_W-1:0] k_rd_word;
    host_op_e          host_op;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] host_rdata_reg;
    logic              host_rvalid_reg;
    logic [31:0]       rd_count_reg;
    logic [31:0]       wr_count_reg;

    assign k_idx      = address0[IDX_W-1:0];
    assign k_in_range = 64'(address0) < 64'(DEPTH);
    assign host_op    = host_op_e'(host_we);

    // Kernel owns the port whenever it drives either strobe.
    assign host_ready = host_en & ~ce0 & ~we0;

    assign k_wr       = we0 & k_in_range;
    assign k_rd_count = ce0 & ~we0 & k_in_range;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = host_addr;
        wr_data = host_wdata;
        if (k_wr) begin
            wr_en   = 1'b1;
            wr_idx  = k_idx;
            wr_data = ad0;
        end else if (host_ready && host_op == HOST_WR) begin
            wr_en = 1'b1;
        end
    end

    // Contents survive reset, so the array sits outside the reset domain.
    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Sampled before this edge's write lands, which gives read-first collisions.
    assign k_rd_word = k_in_range ? mem[k_idx] : '0;

    mem_rd_pipe #(
        .DATA_W(DATA_W),
        .RD_LAT(PIPE_LAT)
    ) u_rd_pipe (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .in_valid(ce0),
        .in_data (k_rd_word),
        .q       (q0)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
        end else begin
            host_rvalid_reg <= 1'b0;
            if (host_ready && host_op == HOST_RD) begin
                host_rdata_reg  <= mem[host_addr];
                host_rvalid_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            if (k_rd_count) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (k_wr) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end
        end
    end

    assign host_rdata  = host_rdata_reg;
    assign host_rvalid = host_rvalid_reg;
    assign rd_count    = rd_count_reg;
    assign wr_count    = wr_count_reg;

`ifdef MEM_PORT_RESPONDER_OOR_CHECK_EN
    logic              err_oor_reg;
    logic [ADDR_W-1:0] oor_addr_reg;

    // Only the first offending address is kept; later ones are ignored until reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_oor_reg  <= 1'b0;
            oor_addr_reg <= '0;
        end else if ((ce0 || we0) && !k_in_range && !err_oor_reg) begin
            err_oor_reg  <= 1'b1;
            oor_addr_reg <= address0;
        end
    end

    assign err_oor = err_oor_reg;
`else
    assign err_oor = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder (DEPTH=256, RD_LAT=2); expected values are hand-computed.
// err_oor expectation follows MEM_PORT_RESPONDER_OOR_CHECK_EN.
module tb_mem_port_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

`ifdef MEM_PORT_RESPONDER_OOR_CHECK_EN
    localparam logic OOR_EXP = 1'b1;
`else
    localparam logic OOR_EXP = 1'b0;
`endif

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              ce0 = 1'b0;
    logic              we0 = 1'b0;
    logic [ADDR_W-1:0] address0 = '0;
    logic [DATA_W-1:0] ad0 = '0;
    logic [DATA_W-1:0] q0;
    logic              host_en = 1'b0;
    logic              host_we = 1'b0;
    logic [7:0]        host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
    logic              err_oor;

    int errors = 0;
    int checks = 0;

    mem_port_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ce0        (ce0),
        .we0        (we0),
        .address0   (address0),
        .ad0        (ad0),
        .q0         (q0),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_oor    (err_oor)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
        int n;
        host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        n = 0;
        while (!host_ready && n < 16) begin
            tick();
            n++;
        end
        if (!host_ready) begin
            checks++; errors++;
            $display("FAIL host_write_grant: addr=%0d host_ready=%b required 1", a, host_ready);
        end
        tick();
        host_en = 1'b0; host_we = 1'b0;
        $display("host write  addr=%0d data=%h", a, d);
    endtask

    task automatic host_read(input logic [7:0] a, output logic [DATA_W-1:0] d,
                             output logic pulse, output logic after);
        int n;
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        n = 0;
        while (!host_ready && n < 16) begin
            tick();
            n++;
        end
        if (!host_ready) begin
            checks++; errors++;
            $display("FAIL host_read_grant: addr=%0d host_ready=%b required 1", a, host_ready);
        end
        tick();
        host_en = 1'b0;
        pulse = host_rvalid;
        d     = host_rdata;
        tick();
        after = host_rvalid;
        $display("host read   addr=%0d data=%h rvalid=%b then %b", a, d, pulse, after);
    endtask

    task automatic kernel_read(input logic [ADDR_W-1:0] a);
        ce0 = 1'b1; address0 = a;
        tick();
        ce0 = 1'b0;
        $display("kernel read addr=%0d", a);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL reset_q0: got %h want 0", q0); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL reset_host_rdata: got %h want 0", host_rdata); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_host_rvalid: got %b want 0", host_rvalid); end
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
        checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err_oor: got %b want 0", err_oor); end
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready: got %b want 0", host_ready); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_load_read();
        logic [DATA_W-1:0] d;
        logic p, a;
        host_write(8'd5, 32'h1234);
        kernel_read(32'd5);
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL load_read_early_t: got %h want 0", q0); end
        tick();
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL load_read_early_t1: got %h want 0", q0); end
        tick();
        checks++; if (q0 !== 32'h1234) begin errors++; $display("FAIL load_read_q0: got %h want 1234", q0); end
        tick(); tick();
        checks++; if (q0 !== 32'h1234) begin errors++; $display("FAIL load_read_hold: got %h want 1234", q0); end
        checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL load_read_rd_count: got %0d want 1", rd_count); end
        host_read(8'd5, d, p, a);
        checks++; if (d !== 32'h1234) begin errors++; $display("FAIL load_host_rdata: got %h want 1234", d); end
    endtask

    task automatic test_kernel_write();
        logic [DATA_W-1:0] d;
        logic p, a;
        we0 = 1'b1; ce0 = 1'b0; address0 = 32'd3; ad0 = 32'hA;
        tick(); tick(); tick();
        we0 = 1'b0;
        $display("kernel write addr=3 data=a x3");
        checks++; if (wr_count !== 32'd3) begin errors++; $display("FAIL kwrite_wr_count: got %0d want 3", wr_count); end
        checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL kwrite_rd_count: got %0d want 1", rd_count); end
        host_read(8'd3, d, p, a);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL kwrite_host_rdata: got %h want a", d); end
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL kwrite_rvalid_pulse: got %b want 1", p); end
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL kwrite_rvalid_drop: got %b want 0", a); end
        checks++; if (host_rdata !== 32'hA) begin errors++; $display("FAIL kwrite_rdata_hold: got %h want a", host_rdata); end
    endtask

    task automatic test_collision();
        host_write(8'd7, 32'h1);
        ce0 = 1'b1; we0 = 1'b1; address0 = 32'd7; ad0 = 32'h2;
        tick();
        ce0 = 1'b0; we0 = 1'b0;
        $display("collision addr=7 ad0=2");
        checks++; if (rd_count !== 32'd1) begin errors++; $display("FAIL collide_rd_count: got %0d want 1", rd_count); end
        checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL collide_wr_count: got %0d want 4", wr_count); end
        tick(); tick();
        checks++; if (q0 !== 32'h1) begin errors++; $display("FAIL collide_read_first: got %h want 1", q0); end
        kernel_read(32'd7);
        tick(); tick();
        checks++; if (q0 !== 32'h2) begin errors++; $display("FAIL collide_new_value: got %h want 2", q0); end
        checks++; if (rd_count !== 32'd2) begin errors++; $display("FAIL collide_rd_count2: got %0d want 2", rd_count); end
    endtask

    task automatic test_back_to_back();
        ce0 = 1'b1;
        address0 = 32'd5; tick();
        address0 = 32'd7; tick();
        address0 = 32'd3; tick();
        ce0 = 1'b0;
        $display("back-to-back reads 5,7,3");
        checks++; if (q0 !== 32'h1234) begin errors++; $display("FAIL b2b_first: got %h want 1234", q0); end
        tick();
        checks++; if (q0 !== 32'h2) begin errors++; $display("FAIL b2b_second: got %h want 2", q0); end
        tick();
        checks++; if (q0 !== 32'hA) begin errors++; $display("FAIL b2b_third: got %h want a", q0); end
        tick();
        checks++; if (q0 !== 32'hA) begin errors++; $display("FAIL b2b_hold: got %h want a", q0); end
        checks++; if (rd_count !== 32'd5) begin errors++; $display("FAIL b2b_rd_count: got %0d want 5", rd_count); end
    endtask

    task automatic test_host_stall();
        host_write(8'd0, 32'hBEEF);
        host_en = 1'b1; host_we = 1'b0; host_addr = 8'd0;
        ce0 = 1'b1; address0 = 32'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_cycle%0d: got %b want 0", i, host_ready); end
            tick();
        end
        ce0 = 1'b0;
        #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL stall_grant: got %b want 1", host_ready); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL stall_early_rvalid: got %b want 0", host_rvalid); end
        tick();
        host_en = 1'b0;
        checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL stall_rvalid: got %b want 1", host_rvalid); end
        checks++; if (host_rdata !== 32'hBEEF) begin errors++; $display("FAIL stall_rdata: got %h want beef", host_rdata); end
        tick();
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL stall_rvalid_drop: got %b want 0", host_rvalid); end
        checks++; if (rd_count !== 32'd9) begin errors++; $display("FAIL stall_rd_count: got %0d want 9", rd_count); end
        $display("host stall 4 cycles then granted");
    endtask

    task automatic test_oor();
        logic [DATA_W-1:0] d;
        logic p, a;
        host_write(8'd44, 32'h44);
        we0 = 1'b1; address0 = 32'd300; ad0 = 32'hDEAD;
        tick();
        we0 = 1'b0;
        $display("kernel write addr=300 (out of range)");
        checks++; if (wr_count !== 32'd4) begin errors++; $display("FAIL oor_wr_count: got %0d want 4", wr_count); end
        checks++; if (err_oor !== OOR_EXP) begin errors++; $display("FAIL oor_flag_write: got %b want %b", err_oor, OOR_EXP); end
        kernel_read(32'd300);
        tick(); tick();
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL oor_read_zero: got %h want 0", q0); end
        checks++; if (rd_count !== 32'd9) begin errors++; $display("FAIL oor_rd_count: got %0d want 9", rd_count); end
        checks++; if (err_oor !== OOR_EXP) begin errors++; $display("FAIL oor_flag_sticky: got %b want %b", err_oor, OOR_EXP); end
        host_read(8'd44, d, p, a);
        checks++; if (d !== 32'h44) begin errors++; $display("FAIL oor_no_alias_write: got %h want 44", d); end
    endtask

    task automatic test_reset_inflight();
        logic [DATA_W-1:0] d;
        logic p, a;
        host_write(8'd1, 32'h55);
        kernel_read(32'd5);
        tick(); tick();
        checks++; if (q0 !== 32'h1234) begin errors++; $display("FAIL rst_pre_q0: got %h want 1234", q0); end
        kernel_read(32'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        $display("reset asserted with read in flight");
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL rst_q0_immediate: got %h want 0", q0); end
        tick(); tick();
        ap_rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL rst_q0_after: got %h want 0", q0); end
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
        checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL rst_wr_count: got %0d want 0", wr_count); end
        checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL rst_err_oor: got %b want 0", err_oor); end
        host_read(8'd1, d, p, a);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL rst_mem_persist: got %h want 55", d); end
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL rst_host_pulse: got %b want 1", p); end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_kernel_write();
        test_collision();
        test_back_to_back();
        test_host_stall();
        test_oor();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
